// File: rtl/modulo_entrada_ataque.sv
// ----------------------------------------------------------------------------
// modulo_entrada_ataque
//   Input-side controller for the attack phase. It debounces the two raw,
//   active-low player buttons and walks the player through line selection,
//   column selection and confirmation. The chosen coordinate is offered to
//   the attack-matrix writer over a valid/ready handshake.
//
//   Ports
//     clk                 system clock
//     clr                 asynchronous active-high reset
//     button_count        raw push-button, active-low, asynchronous
//     button_confirmation raw push-button, active-low, asynchronous
//     hh1[1:0]            game mode, 2'b10 = attack, anything else idles
//     shot_ready          writer accepts the coordinate
//     mdl[2:0]            selected line   0..N_LINES-1
//     mdc[2:0]            selected column 0..N_COLS-1
//     sel_field           0 = editing line, 1 = editing column
//     shot_valid          coordinate offered to the writer
//     busy                controller is out of IDLE
//     dup_err             one-cycle pulse on a rejected duplicate shot
//
//   Build option
//     SHOT_HISTORY_EN     keeps a map of fired cells and rejects repeats
//                         (without it dup_err is tied low)
// ----------------------------------------------------------------------------
module modulo_entrada_ataque #(
   parameter int DEB_CYCLES = 250000,
   parameter int DEB_W      = 18,
   parameter int N_LINES    = 7,
   parameter int N_COLS     = 5
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       button_count,
   input  logic       button_confirmation,
   input  logic [1:0] hh1,
   input  logic       shot_ready,
   output logic [2:0] mdl,
   output logic [2:0] mdc,
   output logic       sel_field,
   output logic       shot_valid,
   output logic       busy,
   output logic       dup_err
);

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [2:0]       L_LAST   = 3'(N_LINES - 1);
   localparam logic [2:0]       C_LAST   = 3'(N_COLS - 1);
   localparam logic [1:0]       MODE_ATK = 2'b10;
   localparam int               BTN_CNT  = 0;
   localparam int               BTN_CONF = 1;

   typedef enum logic [1:0] {IDLE, SEL_LINE, SEL_COL, PENDING} state_t;

   // ------------------------------------------------------------------------
   // Input conditioning: both buttons share one 2-FF synchronizer + debounce
   // datapath, indexed by BTN_CNT / BTN_CONF. Idle level of all stages is 1.
   // ------------------------------------------------------------------------
   logic [1:0]            raw;
   logic [1:0]            sync1_q, sync2_q;
   logic [1:0]            deb_q, deb_d;
   logic [1:0][DEB_W-1:0] cnt_q, cnt_d;
   logic [1:0]            press;

   assign raw = {button_confirmation, button_count};

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         cnt_d[b] = '0;
         deb_d[b] = deb_q[b];
         press[b] = 1'b0;
         // Counter only runs while the synced level disagrees with the
         // accepted level; any agreement restarts the stability window.
         if (sync2_q[b] != deb_q[b]) begin
            if (cnt_q[b] == DEB_LAST) begin
               deb_d[b] = sync2_q[b];
               press[b] = ~sync2_q[b];   // only the 1->0 acceptance is an event
            end else begin
               cnt_d[b] = cnt_q[b] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync1_q <= '1;
         sync2_q <= '1;
         deb_q   <= '1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

   // Confirm wins a same-cycle tie; the count event is simply dropped.
   logic cnt_ev, conf_ev;
   assign conf_ev = press[BTN_CONF];
   assign cnt_ev  = press[BTN_CNT] & ~press[BTN_CONF];

   // ------------------------------------------------------------------------
   // Selection FSM with registered outputs
   // ------------------------------------------------------------------------
   state_t     state_q;
   logic [2:0] mdl_q, mdc_q;
   logic       sel_q, valid_q, busy_q;

`ifdef SHOT_HISTORY_EN
   localparam int MAP_W  = N_LINES * N_COLS;
   localparam int CELL_W = $clog2(MAP_W);

   logic [MAP_W-1:0]  fired_q;
   logic              dup_q;
   logic [CELL_W-1:0] cell;

   assign cell = CELL_W'(32'(mdl_q) * N_COLS + 32'(mdc_q));
`endif

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         mdl_q   <= '0;
         mdc_q   <= '0;
         sel_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
`ifdef SHOT_HISTORY_EN
         fired_q <= '0;
         dup_q   <= 1'b0;
`endif
      end else begin
`ifdef SHOT_HISTORY_EN
         dup_q <= 1'b0;
`endif
         if (hh1 != MODE_ATK) begin
            // Leaving attack mode abandons any offered shot.
            state_q <= IDLE;
            mdl_q   <= '0;
            mdc_q   <= '0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SHOT_HISTORY_EN
            fired_q <= '0;
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= SEL_LINE;
                  busy_q  <= 1'b1;
                  sel_q   <= 1'b0;
               end
               SEL_LINE: begin
                  if (conf_ev) begin
                     state_q <= SEL_COL;
                     sel_q   <= 1'b1;
                  end else if (cnt_ev) begin
                     mdl_q <= (mdl_q == L_LAST) ? 3'd0 : mdl_q + 3'd1;
                  end
               end
               SEL_COL: begin
                  if (conf_ev) begin
`ifdef SHOT_HISTORY_EN
                     if (fired_q[cell]) begin
                        dup_q <= 1'b1;
                     end else begin
                        state_q <= PENDING;
                        valid_q <= 1'b1;
                     end
`else
                     state_q <= PENDING;
                     valid_q <= 1'b1;
`endif
                  end else if (cnt_ev) begin
                     mdc_q <= (mdc_q == C_LAST) ? 3'd0 : mdc_q + 3'd1;
                  end
               end
               PENDING: begin
                  // Coordinates frozen, button events discarded; gating on
                  // valid_q means ready only counts once PENDING is visible.
                  if (valid_q && shot_ready) begin
                     state_q <= SEL_LINE;
                     mdl_q   <= '0;
                     mdc_q   <= '0;
                     sel_q   <= 1'b0;
                     valid_q <= 1'b0;
`ifdef SHOT_HISTORY_EN
                     fired_q[cell] <= 1'b1;
`endif
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign mdl        = mdl_q;
   assign mdc        = mdc_q;
   assign sel_field  = sel_q;
   assign shot_valid = valid_q;
   assign busy       = busy_q;
`ifdef SHOT_HISTORY_EN
   assign dup_err    = dup_q;
`else
   assign dup_err    = 1'b0;
`endif

endmodule

// File: tb/tb_modulo_entrada_ataque.sv
// ----------------------------------------------------------------------------
// Bench for modulo_entrada_ataque with a short debounce window (4 cycles).
// Inputs change 1 time unit after a rising edge and outputs are read there
// too; transfers are checked against a queue of expected coordinates.
// ----------------------------------------------------------------------------
module tb_modulo_entrada_ataque;
   localparam int DEB = 4;

   logic       clk, clr, bc, bf, shot_ready;
   logic [1:0] hh1;
   logic [2:0] mdl, mdc;
   logic       sel_field, shot_valid, busy, dup_err;

   int nvec  = 0;
   int nerr  = 0;
   int xfers = 0;
   int dups  = 0;
   logic [5:0] exp_q[$];

   modulo_entrada_ataque #(
      .DEB_CYCLES(DEB), .DEB_W(3), .N_LINES(7), .N_COLS(5)
   ) dut (
      .clk(clk), .clr(clr),
      .button_count(bc), .button_confirmation(bf),
      .hh1(hh1), .shot_ready(shot_ready),
      .mdl(mdl), .mdc(mdc), .sel_field(sel_field),
      .shot_valid(shot_valid), .busy(busy), .dup_err(dup_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Press long enough to be accepted, then release long enough to settle.
   task automatic press(input bit c, input bit f);
      if (c) bc = 1'b0;
      if (f) bf = 1'b0;
      tick(DEB + 4);
      bc = 1'b1;
      bf = 1'b1;
      tick(DEB + 4);
   endtask

   task automatic presses(input int n);
      for (int i = 0; i < n; i++) press(1'b1, 1'b0);
   endtask

   // Transfer monitor: a transfer happens on the edge following a low phase
   // where valid and ready are both high in attack mode.
   always @(negedge clk) begin
      logic [5:0] e;
      if (dup_err === 1'b1) dups++;
      if (!clr && hh1 == 2'b10 && shot_valid && shot_ready) begin
         xfers++;
         chk("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("xfer_coord", 32'({mdl, mdc}), 32'(e));
         end
      end
   end

   initial begin
      int exp_xfers;
      exp_xfers  = 0;
      bc         = 1'b1;
      bf         = 1'b1;
      hh1        = 2'b00;
      shot_ready = 1'b0;
      clr        = 1'b0;
      #1 clr = 1'b1;
      #1;
      chk("rst_mdl", 32'(mdl), 32'd0);
      chk("rst_mdc", 32'(mdc), 32'd0);
      chk("rst_sel", 32'(sel_field), 32'd0);
      chk("rst_valid", 32'(shot_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_dup", 32'(dup_err), 32'd0);
      tick(3);
      clr = 1'b0;
      tick(2);
      chk("idle_busy", 32'(busy), 32'd0);
      hh1 = 2'b10;
      tick(1);
      chk("enter_busy", 32'(busy), 32'd1);
      chk("enter_sel", 32'(sel_field), 32'd0);

      // Line wrap 1..6,0 then column wrap 1..4,0
      for (int i = 0; i < 7; i++) begin
         press(1'b1, 1'b0);
         chk("wrap_mdl", 32'(mdl), 32'((i + 1) % 7));
      end
      press(1'b0, 1'b1);
      chk("col_sel", 32'(sel_field), 32'd1);
      for (int i = 0; i < 5; i++) begin
         press(1'b1, 1'b0);
         chk("wrap_mdc", 32'(mdc), 32'((i + 1) % 5));
      end
      chk("wrap_mdl_kept", 32'(mdl), 32'd0);
      press(1'b0, 1'b1);
      chk("pend00_valid", 32'(shot_valid), 32'd1);
      exp_q.push_back(6'b000_000);
      exp_xfers++;
      shot_ready = 1'b1;
      tick(1);
      shot_ready = 1'b0;
      chk("xfer00_valid", 32'(shot_valid), 32'd0);

      // Debounce: bounce every 2 cycles for 20 cycles then hold low
      for (int i = 0; i < 10; i++) begin
         bc = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick(2);
      end
      bc = 1'b0;
      tick(DEB + 1);
      chk("deb_before", 32'(mdl), 32'd0);
      tick(1);
      chk("deb_at_latency", 32'(mdl), 32'd1);
      tick(100);
      chk("deb_held", 32'(mdl), 32'd1);
      bc = 1'b1;
      tick(DEB + 4);
      chk("deb_release", 32'(mdl), 32'd1);

      // Simultaneous count and confirm: confirm wins
      press(1'b1, 1'b1);
      chk("prio_sel", 32'(sel_field), 32'd1);
      chk("prio_mdl", 32'(mdl), 32'd1);
      chk("prio_mdc", 32'(mdc), 32'd0);

      // Back through IDLE to start fresh
      hh1 = 2'b01;
      tick(1);
      chk("idle2_busy", 32'(busy), 32'd0);
      chk("idle2_mdl", 32'(mdl), 32'd0);
      hh1 = 2'b10;
      tick(1);

      // Handshake at (4,1) with ready held low
      presses(4);
      press(1'b0, 1'b1);
      presses(1);
      press(1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         chk("hs_valid", 32'(shot_valid), 32'd1);
         chk("hs_coord", 32'({mdl, mdc}), 32'({3'd4, 3'd1}));
         tick(1);
      end
      press(1'b1, 1'b0);
      chk("hs_ignore_cnt", 32'({mdl, mdc}), 32'({3'd4, 3'd1}));
      chk("hs_still_valid", 32'(shot_valid), 32'd1);
      exp_q.push_back({3'd4, 3'd1});
      exp_xfers++;
      shot_ready = 1'b1;
      tick(1);
      shot_ready = 1'b0;
      chk("hs_done_valid", 32'(shot_valid), 32'd0);
      chk("hs_done_coord", 32'({mdl, mdc}), 32'd0);
      chk("hs_done_sel", 32'(sel_field), 32'd0);
      chk("hs_done_busy", 32'(busy), 32'd1);

      // Mode abort during PENDING at (3,2)
      presses(3);
      press(1'b0, 1'b1);
      presses(2);
      press(1'b0, 1'b1);
      chk("ab_valid", 32'(shot_valid), 32'd1);
      hh1 = 2'b01;
      tick(1);
      chk("ab_valid_drop", 32'(shot_valid), 32'd0);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_coord", 32'({mdl, mdc}), 32'd0);
      hh1 = 2'b10;
      tick(1);

      // Asynchronous reset mid-PENDING at (3,2)
      presses(3);
      press(1'b0, 1'b1);
      presses(2);
      press(1'b0, 1'b1);
      chk("pr_coord", 32'({mdl, mdc}), 32'({3'd3, 3'd2}));
      chk("pr_valid", 32'(shot_valid), 32'd1);
      #3 clr = 1'b1;
      #1;
      chk("ar_mdl", 32'(mdl), 32'd0);
      chk("ar_mdc", 32'(mdc), 32'd0);
      chk("ar_valid", 32'(shot_valid), 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_sel", 32'(sel_field), 32'd0);
      tick(2);
      clr = 1'b0;
      tick(1);
      chk("ar_reenter_busy", 32'(busy), 32'd1);

`ifdef SHOT_HISTORY_EN
      // Fire (2,3), then try it again
      presses(2);
      press(1'b0, 1'b1);
      presses(3);
      press(1'b0, 1'b1);
      exp_q.push_back({3'd2, 3'd3});
      exp_xfers++;
      shot_ready = 1'b1;
      tick(1);
      shot_ready = 1'b0;
      presses(2);
      press(1'b0, 1'b1);
      presses(3);
      chk("dup_pre", 32'(dups), 32'd0);
      press(1'b0, 1'b1);
      chk("dup_pulse", 32'(dups), 32'd1);
      chk("dup_sel", 32'(sel_field), 32'd1);
      chk("dup_valid", 32'(shot_valid), 32'd0);
      chk("dup_mdc", 32'(mdc), 32'd3);
      presses(1);
      press(1'b0, 1'b1);
      chk("dup_next_valid", 32'(shot_valid), 32'd1);
      chk("dup_next_coord", 32'({mdl, mdc}), 32'({3'd2, 3'd4}));
      chk("dup_total", 32'(dups), 32'd1);
`else
      chk("dup_total", 32'(dups), 32'd0);
`endif

      chk("xfer_count", 32'(xfers), 32'(exp_xfers));
      chk("xfer_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/modulo_entrada_ataque.md
Name: modulo_entrada_ataque

Overview:
Input-side controller for the attack phase. It debounces the two raw player push-buttons and walks the player through line selection, then column selection, then confirmation. The selected coordinate is presented to the attack-matrix writer with a valid/ready handshake. It is the producer of the coordinate word (mdl line 0-6, mdc column 0-4) that the display and storage path consumes.

Parameters:
DEB_CYCLES, 250000, consecutive stable clk samples required to accept a button level change
DEB_W, 18, width of debounce counter; must satisfy 2^DEB_W > DEB_CYCLES
N_LINES, 7, number of matrix lines; mdl wraps at N_LINES-1
N_COLS, 5, number of matrix columns; mdc wraps at N_COLS-1

Ports:
clk  input  1  system clock
clr  input  1  asynchronous active-high reset
button_count  input  1  raw push-button, active-low (0 = pressed), asynchronous to clk
button_confirmation  input  1  raw push-button, active-low, asynchronous to clk
hh1  input  2  game mode; 2'b10 = attack; any other value disables the block
shot_ready  input  1  attack-matrix writer accepts the coordinate
mdl  output  3  selected line, binary 0..N_LINES-1
mdc  output  3  selected column, binary 0..N_COLS-1
sel_field  output  1  0 = editing line, 1 = editing column (drives 7-seg blink)
shot_valid  output  1  coordinate stable and offered to the writer
busy  output  1  high in any state other than IDLE
dup_err  output  1  one-cycle pulse on a rejected duplicate shot (see Optional Feature)

Behaviour:
- Reset (clr=1, async): state=IDLE; mdl=0, mdc=0; sel_field=0, shot_valid=0, busy=0, dup_err=0; debounce counters=0; debounced levels=released(1).
- Input conditioning, per button: 2-FF synchronizer, then debounce.
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise the counter increments. At DEB_CYCLES-1 the debounced level takes the synced level and the counter clears.
  - Press event = one-cycle pulse on a debounced 1->0 transition.
  - Latency from a stable raw edge to the pulse is 2+DEB_CYCLES clk cycles.
  - Release generates nothing. A held button yields exactly one event.
- Both press events in the same cycle: the confirm event wins and the count event is dropped.
- FSM:
  - IDLE: entered whenever hh1!=2'b10, from any state, on the next edge. On entry mdl=mdc=0 and shot_valid is dropped. Moves to SEL_LINE when hh1==2'b10.
  - SEL_LINE (sel_field=0): count event -> mdl=mdl+1, or 0 if mdl==N_LINES-1. Confirm event -> SEL_COL.
  - SEL_COL (sel_field=1): count event -> mdc=mdc+1, or 0 if mdc==N_COLS-1. Confirm event -> PENDING.
  - PENDING: shot_valid=1; mdl/mdc frozen; button events are ignored and discarded. When shot_valid&&shot_ready on a clk edge -> SEL_LINE with mdl=mdc=0, and shot_valid goes low the next cycle.
  - shot_ready sampled high in the same cycle PENDING is entered counts only from the first PENDING cycle onward. The minimum valid pulse is 1 cycle.
- Handshake rule: once shot_valid rises, mdl/mdc do not change and it does not fall until the transfer completes or the mode changes.
- Mode change mid-PENDING abandons the shot; no transfer occurs.
- Counters never exceed the wrap bound. Out-of-range values are unreachable.

Optional Feature:
- SHOT_HISTORY_EN defined:
  - Adds an N_LINES*N_COLS-bit fired map, bit index mdl*N_COLS+mdc, set on each completed transfer.
  - A confirm in SEL_COL on a cell whose bit is set stays in SEL_COL, pulses dup_err for 1 cycle, and keeps mdc.
  - The map clears on clr or on entry to IDLE.
- Not defined: no map; every SEL_COL confirm goes to PENDING; dup_err tied 0.

Test Plan:
- Bench uses DEB_CYCLES=4.
- Reset: assert clr mid-PENDING with mdl=3, mdc=2 -> all outputs 0 immediately, state IDLE.
- Debounce: button_count bounces 0/1 every 2 cycles for 20 cycles then holds 0, in SEL_LINE -> mdl increments exactly once, 6 cycles after the last edge; holding for 100 cycles gives no further increments.
- Wrap: 7 count presses in SEL_LINE -> mdl 1..6 then 0. Confirm, then 5 count presses in SEL_COL -> mdc 1..4 then 0.
- Handshake: select mdl=4, mdc=1, confirm, hold shot_ready=0 for 10 cycles -> shot_valid=1 with coords stable; count presses ignored. Raise shot_ready 1 cycle -> one transfer, then SEL_LINE with mdl=mdc=0.
- Mode abort and priority: hh1 to 2'b01 during PENDING -> shot_valid=0 next cycle, IDLE. Simultaneous count and confirm in SEL_LINE -> SEL_COL with mdl unchanged.
- SHOT_HISTORY_EN: fire (2,3), then confirm (2,3) again -> dup_err one-cycle pulse, stays SEL_COL. Confirm (2,4) -> PENDING.
